// File: rtl/seta_matriz_scan.sv
// -----------------------------------------------------------------------------
// seta_matriz_scan
//   Row-multiplexed driver for the elevator direction arrow on a COLS x ROWS
//   LED matrix. Rows are scanned one at a time, SCAN_DIV clocks per row slot.
//   The arrow glyph scrolls in the direction of travel one row every ANIM_DIV
//   frames.
//
//   Ports
//     clk         in   rising-edge system clock
//     reset       in   synchronous, active-high
//     enable      in   1 = drive the matrix, 0 = blank outputs and freeze state
//     direcao     in   00 idle, 01 up, 10 down, 11 idle
//     colunas     out  column data, active-high
//     linhas      out  row select, active-low, one-hot-zero (bit 0 = top row)
//     quadro_fim  out  one-cycle pulse marking the last cycle of each frame
//
//   Optional feature macro: SETA_PISCA_EN
//     When defined, idle shows a blinking vertical stop bar instead of a blank
//     matrix.
// -----------------------------------------------------------------------------
module seta_matriz_scan #(
  parameter int COLS     = 5,
  parameter int ROWS     = 7,
  parameter int SCAN_DIV = 1000,
  parameter int ANIM_DIV = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [1:0]      direcao,
  output logic [COLS-1:0] colunas,
  output logic [ROWS-1:0] linhas,
  output logic            quadro_fim
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  // One extra bit so row+off and row+ROWS-off never overflow before the wrap.
  localparam int RW = $clog2(ROWS) + 1;
  localparam int FW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int C  = COLS / 2;

  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
  localparam logic [RW-1:0] ROWS_W     = RW'(ROWS);
  localparam logic [FW-1:0] FRAME_LAST = FW'(ANIM_DIV - 1);

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  // Down-arrow glyph: a shaft in column C, the full-width bar, the narrowing
  // head, then the tip. The up glyph is the same table read bottom-up.
  function automatic logic [COLS-1:0] glyph_down(input logic [RW-1:0] idx);
    logic [COLS-1:0] g;
    g = {COLS{1'b0}};
    for (int i = 0; i < COLS; i++) begin
      if (idx == RW'(ROWS - 3)) begin
        g[i] = 1'b1;
      end else if (idx == RW'(ROWS - 2)) begin
        g[i] = (i >= C - 1) && (i <= C + 1);
      end else begin
        g[i] = (i == C);
      end
    end
    return g;
  endfunction

  logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
  logic [RW-1:0]   row_q, row_d;
  logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
  logic [RW-1:0]   off_q, off_d;
  logic [1:0]      dir_q, dir_d;
  logic [COLS-1:0] colunas_q, colunas_d;
  logic [ROWS-1:0] linhas_q, linhas_d;
  logic            quadro_fim_q, quadro_fim_d;
`ifdef SETA_PISCA_EN
  logic            pisca_q, pisca_d;
`endif

  logic            scan_wrap_s, row_wrap_s, frame_wrap_s;
  logic [1:0]      dir_in_s;
  logic [RW-1:0]   row_add_s, row_sub_s;
  logic [COLS-1:0] idle_data_s, row_data_s;

  assign scan_wrap_s  = (scan_cnt_q == SCAN_LAST);
  assign row_wrap_s   = (row_q == ROW_LAST);
  assign frame_wrap_s = (frame_cnt_q == FRAME_LAST);
  assign dir_in_s     = (direcao == 2'b11) ? DIR_IDLE : direcao;

`ifdef SETA_PISCA_EN
  assign idle_data_s = pisca_q ? glyph_down({RW{1'b0}}) : {COLS{1'b0}};
`else
  assign idle_data_s = {COLS{1'b0}};
`endif

  // Glyph row selection: (row+off) mod ROWS and (row-off) mod ROWS.
  always_comb begin
    row_add_s = row_q + off_q;
    if (row_add_s >= ROWS_W) begin
      row_add_s = row_add_s - ROWS_W;
    end else begin
      row_add_s = row_add_s;
    end
    row_sub_s = row_q + ROWS_W - off_q;
    if (row_sub_s >= ROWS_W) begin
      row_sub_s = row_sub_s - ROWS_W;
    end else begin
      row_sub_s = row_sub_s;
    end
    case (dir_q)
      DIR_DOWN: row_data_s = glyph_down(row_sub_s);
      DIR_UP:   row_data_s = glyph_down(ROW_LAST - row_add_s);
      default:  row_data_s = idle_data_s;
    endcase
  end

  // Next-state for counters, scroll offset, direction and registered outputs.
  always_comb begin
    scan_cnt_d   = scan_cnt_q;
    row_d        = row_q;
    frame_cnt_d  = frame_cnt_q;
    off_d        = off_q;
    dir_d        = dir_q;
`ifdef SETA_PISCA_EN
    pisca_d      = pisca_q;
`endif
    colunas_d    = {COLS{1'b0}};
    linhas_d     = {ROWS{1'b1}};
    quadro_fim_d = 1'b0;
    if (enable) begin
      linhas_d     = ~({{(ROWS-1){1'b0}}, 1'b1} << row_q);
      quadro_fim_d = scan_wrap_s && row_wrap_s;
      // First cycle of each row slot is blanked to hide row-switch ghosting.
      if (scan_cnt_q == {SW{1'b0}}) begin
        colunas_d = {COLS{1'b0}};
      end else begin
        colunas_d = row_data_s;
      end
      if (scan_wrap_s) begin
        scan_cnt_d = {SW{1'b0}};
        if (row_wrap_s) begin
          // Frame boundary: the only point where direcao is taken in.
          row_d = {RW{1'b0}};
          dir_d = dir_in_s;
          if (dir_in_s != dir_q) begin
            off_d       = {RW{1'b0}};
            frame_cnt_d = {FW{1'b0}};
`ifdef SETA_PISCA_EN
            pisca_d     = 1'b1;
`endif
          end else if (frame_wrap_s) begin
            frame_cnt_d = {FW{1'b0}};
`ifdef SETA_PISCA_EN
            pisca_d     = ~pisca_q;
`endif
            if (dir_q == DIR_IDLE) begin
              off_d = {RW{1'b0}};
            end else if (off_q == ROW_LAST) begin
              off_d = {RW{1'b0}};
            end else begin
              off_d = off_q + RW'(1);
            end
          end else begin
            frame_cnt_d = frame_cnt_q + FW'(1);
          end
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        scan_cnt_d = scan_cnt_q + SW'(1);
      end
    end else begin
      scan_cnt_d = scan_cnt_q;
      row_d      = row_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt_q   <= {SW{1'b0}};
      row_q        <= {RW{1'b0}};
      frame_cnt_q  <= {FW{1'b0}};
      off_q        <= {RW{1'b0}};
      dir_q        <= DIR_IDLE;
      colunas_q    <= {COLS{1'b0}};
      linhas_q     <= {ROWS{1'b1}};
      quadro_fim_q <= 1'b0;
`ifdef SETA_PISCA_EN
      pisca_q      <= 1'b1;
`endif
    end else begin
      scan_cnt_q   <= scan_cnt_d;
      row_q        <= row_d;
      frame_cnt_q  <= frame_cnt_d;
      off_q        <= off_d;
      dir_q        <= dir_d;
      colunas_q    <= colunas_d;
      linhas_q     <= linhas_d;
      quadro_fim_q <= quadro_fim_d;
`ifdef SETA_PISCA_EN
      pisca_q      <= pisca_d;
`endif
    end
  end

  assign colunas    = colunas_q;
  assign linhas     = linhas_q;
  assign quadro_fim = quadro_fim_q;

endmodule

// File: tb/tb_seta_matriz_scan.sv
// -----------------------------------------------------------------------------
// tb_seta_matriz_scan
//   Directed bench for seta_matriz_scan with COLS=5, ROWS=7, SCAN_DIV=4,
//   ANIM_DIV=2 (28-cycle frames, scroll step every 2 frames).
// -----------------------------------------------------------------------------
module tb_seta_matriz_scan;

  localparam int FRAME = 28;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [1:0] direcao;
  logic [4:0] colunas;
  logic [6:0] linhas;
  logic       quadro_fim;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [4:0] cols_cap [FRAME];
  logic [6:0] lin_cap  [FRAME];
  logic       qf_cap   [FRAME];
  logic [4:0] idle_bar;

  always #5 clk = ~clk;

  seta_matriz_scan #(
    .COLS(5), .ROWS(7), .SCAN_DIV(4), .ANIM_DIV(2)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .direcao(direcao),
    .colunas(colunas), .linhas(linhas), .quadro_fim(quadro_fim)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one 28-cycle frame, optionally changing direcao at cycle switch_at.
  task automatic capture_frame(input int switch_at, input logic [1:0] new_dir);
    for (int i = 0; i < FRAME; i++) begin
      if (i == switch_at) direcao = new_dir;
      tick();
      cols_cap[i] = colunas;
      lin_cap[i]  = linhas;
      qf_cap[i]   = quadro_fim;
    end
  endtask

  function automatic logic [FRAME-1:0] qf_vec();
    logic [FRAME-1:0] v;
    for (int i = 0; i < FRAME; i++) v[i] = qf_cap[i];
    return v;
  endfunction

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; direcao = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if ({colunas, linhas, quadro_fim} !== {5'b00000, 7'b1111111, 1'b0}) begin
        tests_failed++;
        $display("FAIL reset_cycle%0d: got c=%b l=%b q=%b expected c=00000 l=1111111 q=0",
                 i, colunas, linhas, quadro_fim);
      end
    end
  endtask

  task automatic test_down_start();
    reset = 1'b0; enable = 1'b1; direcao = 2'b10;
    // frame 1 still idle
    capture_frame(-1, 2'b10);
    tests_run++;
    if (cols_cap[17] !== idle_bar || cols_cap[16] !== 5'b00000) begin
      tests_failed++;
      $display("FAIL frame1_idle: got %b/%b expected 00000/%b", cols_cap[16], cols_cap[17], idle_bar);
    end
    tests_run++;
    if (qf_vec() !== {1'b1, 27'd0}) begin
      tests_failed++;
      $display("FAIL frame1_qf: got %b expected pulse at cycle 27 only", qf_vec());
    end
    tests_run++;
    if (lin_cap[0] !== 7'b1111110 || lin_cap[27] !== 7'b0111111) begin
      tests_failed++;
      $display("FAIL frame1_linhas: got %b/%b expected 1111110/0111111", lin_cap[0], lin_cap[27]);
    end
    // frame 2: down, off=0
    capture_frame(-1, 2'b10);
    tests_run++;
    if ({cols_cap[0], cols_cap[1], cols_cap[2], cols_cap[3]} !== {5'b00000, 5'b00100, 5'b00100, 5'b00100}) begin
      tests_failed++;
      $display("FAIL down_row0_slot: got %b %b %b %b expected 00000 00100 00100 00100",
               cols_cap[0], cols_cap[1], cols_cap[2], cols_cap[3]);
    end
    tests_run++;
    if (cols_cap[16] !== 5'b00000 || cols_cap[17] !== 5'b11111 || lin_cap[16] !== 7'b1101111) begin
      tests_failed++;
      $display("FAIL down_row4: got %b %b l=%b expected 00000 11111 l=1101111", cols_cap[16], cols_cap[17], lin_cap[16]);
    end
    tests_run++;
    if (cols_cap[21] !== 5'b01110) begin
      tests_failed++;
      $display("FAIL down_row5: got %b expected 01110", cols_cap[21]);
    end
    // frame 3: still off=0
    capture_frame(-1, 2'b10);
    tests_run++;
    if (cols_cap[17] !== 5'b11111) begin
      tests_failed++;
      $display("FAIL down_frame3_row4: got %b expected 11111", cols_cap[17]);
    end
  endtask

  task automatic test_down_scroll();
    int k;
    // frames 4 and 5: off=1
    capture_frame(-1, 2'b10);
    tests_run++;
    if (cols_cap[1] !== 5'b00100 || cols_cap[17] !== 5'b00100 || cols_cap[21] !== 5'b11111) begin
      tests_failed++;
      $display("FAIL down_off1: got r0=%b r4=%b r5=%b expected 00100 00100 11111",
               cols_cap[1], cols_cap[17], cols_cap[21]);
    end
    capture_frame(-1, 2'b10);
    tests_run++;
    if (cols_cap[21] !== 5'b11111) begin
      tests_failed++;
      $display("FAIL down_off1_frame5: got %b expected 11111", cols_cap[21]);
    end
    // frames 6..17: the bar sits on row (4+off) mod 7, the head on (5+off) mod 7
    for (int f = 6; f <= 17; f++) begin
      capture_frame(-1, 2'b10);
      k = ((f - 2) / 2) % 7;
      tests_run++;
      if (cols_cap[4 * ((4 + k) % 7) + 1] !== 5'b11111) begin
        tests_failed++;
        $display("FAIL down_scroll_bar f%0d: got %b expected 11111", f, cols_cap[4 * ((4 + k) % 7) + 1]);
      end
      tests_run++;
      if (cols_cap[4 * ((5 + k) % 7) + 2] !== 5'b01110) begin
        tests_failed++;
        $display("FAIL down_scroll_head f%0d: got %b expected 01110", f, cols_cap[4 * ((5 + k) % 7) + 2]);
      end
    end
    tests_run++;
    if (cols_cap[17] !== 5'b11111 || cols_cap[25] !== 5'b00100) begin
      tests_failed++;
      $display("FAIL off_wrap: got r4=%b r6=%b expected 11111 00100", cols_cap[17], cols_cap[25]);
    end
  endtask

  task automatic test_dir_switch();
    // frame 18: down off=1, switch to up in row 3
    capture_frame(13, 2'b01);
    tests_run++;
    if (cols_cap[21] !== 5'b11111 || cols_cap[17] !== 5'b00100) begin
      tests_failed++;
      $display("FAIL no_tear: got r5=%b r4=%b expected 11111 00100", cols_cap[21], cols_cap[17]);
    end
    tests_run++;
    if (qf_vec() !== {1'b1, 27'd0}) begin
      tests_failed++;
      $display("FAIL switch_qf: got %b expected pulse at cycle 27 only", qf_vec());
    end
    // frame 19: up off=0
    capture_frame(-1, 2'b01);
    tests_run++;
    if (cols_cap[9] !== 5'b11111 || cols_cap[5] !== 5'b01110 || cols_cap[25] !== 5'b00100) begin
      tests_failed++;
      $display("FAIL up_off0: got r2=%b r1=%b r6=%b expected 11111 01110 00100",
               cols_cap[9], cols_cap[5], cols_cap[25]);
    end
    capture_frame(-1, 2'b01);
    tests_run++;
    if (cols_cap[9] !== 5'b11111) begin
      tests_failed++;
      $display("FAIL up_off0_frame20: got %b expected 11111", cols_cap[9]);
    end
    // frame 21: up off=1, bar moved up to row 1
    capture_frame(-1, 2'b01);
    tests_run++;
    if (cols_cap[5] !== 5'b11111 || cols_cap[1] !== 5'b01110) begin
      tests_failed++;
      $display("FAIL up_off1: got r1=%b r0=%b expected 11111 01110", cols_cap[5], cols_cap[1]);
    end
  endtask

  task automatic test_enable_hold();
    int bad;
    // frame 22: up off=1; stop after row 4 scan 1
    for (int i = 0; i < 18; i++) tick();
    enable = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if ({colunas, linhas, quadro_fim} !== {5'b00000, 7'b1111111, 1'b0}) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL disabled_blank: got %0d non-blank cycles expected 0", bad);
    end
    enable = 1'b1;
    tick();
    tests_run++;
    if (linhas !== 7'b1101111 || colunas !== 5'b00100) begin
      tests_failed++;
      $display("FAIL resume_row4: got l=%b c=%b expected l=1101111 c=00100", linhas, colunas);
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (quadro_fim !== 1'b0) bad++;
    end
    tick();
    tests_run++;
    if (bad !== 0 || quadro_fim !== 1'b1 || linhas !== 7'b0111111) begin
      tests_failed++;
      $display("FAIL stretched_frame_end: got early=%0d q=%b l=%b expected 0 1 0111111", bad, quadro_fim, linhas);
    end
  endtask

  task automatic test_idle();
    int bad;
    logic [4:0] exp;
    capture_frame(0, 2'b00);
    for (int f = 0; f < 4; f++) begin
      capture_frame(-1, 2'b00);
`ifdef SETA_PISCA_EN
      exp = (f < 2) ? 5'b00100 : 5'b00000;
`else
      exp = 5'b00000;
`endif
      bad = 0;
      for (int i = 0; i < FRAME; i++) begin
        if (cols_cap[i] !== (((i % 4) == 0) ? 5'b00000 : exp)) bad++;
      end
      tests_run++;
      if (bad !== 0) begin
        tests_failed++;
        $display("FAIL idle_frame%0d: got %0d wrong cycles (r0=%b) expected all %b", f, bad, cols_cap[1], exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    capture_frame(0, 2'b10);
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1;
    tick();
    tests_run++;
    if ({colunas, linhas, quadro_fim} !== {5'b00000, 7'b1111111, 1'b0}) begin
      tests_failed++;
      $display("FAIL mid_reset_out: got c=%b l=%b q=%b expected 00000 1111111 0", colunas, linhas, quadro_fim);
    end
    reset = 1'b0;
    capture_frame(-1, 2'b10);
    tests_run++;
    if (cols_cap[17] !== idle_bar || qf_vec() !== {1'b1, 27'd0} || lin_cap[0] !== 7'b1111110) begin
      tests_failed++;
      $display("FAIL after_reset_frame: got r4=%b qf=%b l0=%b expected %b pulse@27 1111110",
               cols_cap[17], qf_vec(), lin_cap[0], idle_bar);
    end
    capture_frame(-1, 2'b10);
    tests_run++;
    if (cols_cap[17] !== 5'b11111 || cols_cap[21] !== 5'b01110) begin
      tests_failed++;
      $display("FAIL after_reset_down: got r4=%b r5=%b expected 11111 01110", cols_cap[17], cols_cap[21]);
    end
  endtask

  initial begin
`ifdef SETA_PISCA_EN
    idle_bar = 5'b00100;
`else
    idle_bar = 5'b00000;
`endif
    reset = 1'b1; enable = 1'b0; direcao = 2'b00;
    test_reset();
    test_down_start();
    test_down_scroll();
    test_dir_switch();
    test_enable_hold();
    test_idle();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
